mips_decode_alu: RTL and testbench



---
 rtl/mips_pkg.sv | 59 +++++
 rtl/mips_alu.sv | 33 +++
 rtl/mips_decode_alu.sv | 89 ++++++++
 tb/tb_mips_decode_alu.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS decode/execute slice: opcodes, functs,
// ALU operation codes and the main-control word layout.
package mips_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned IMM_W     = 16;
  localparam int unsigned ALU_CTL_W = 4;
  localparam int unsigned ALU_OP_W  = 2;
  localparam int unsigned CTRL_W    = 8;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_CTL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_CTL_W-1:0] ALU_NOR = 4'b1100;

  localparam logic [ALU_OP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALUOP_FUNCT = 2'b10;

  // Bit positions inside the 8-bit control word
  localparam int unsigned CTRL_REG_DST    = 7;
  localparam int unsigned CTRL_ALU_SRC    = 6;
  localparam int unsigned CTRL_MEM_TO_REG = 5;
  localparam int unsigned CTRL_REG_WRITE  = 4;
  localparam int unsigned CTRL_MEM_WRITE  = 3;
  localparam int unsigned CTRL_BRANCH     = 2;
  localparam int unsigned CTRL_ALU_OP_HI  = 1;
  localparam int unsigned CTRL_ALU_OP_LO  = 0;

  typedef struct packed {
    logic                reg_dst;
    logic                alu_src;
    logic                mem_to_reg;
    logic                reg_write;
    logic                mem_write;
    logic                branch;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/mips_alu.sv
// Purely combinational 32-bit ALU; also usable as a plain adder with ctl = ALU_ADD.
module mips_alu
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic [ALU_CTL_W-1:0] ctl,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     result,
  output logic                 zero
);

  logic lt;

  assign lt = ($signed(a) < $signed(b));

  always_comb begin
    result = '0;
    case (ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_decode_alu.sv
// ID/EX core: main control and ALU control decode, operand-B select, ALU, and the
// EX-stage result register.
module mips_decode_alu
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [OP_W-1:0]      opcode,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic [WIDTH-1:0]     rs_data,
  input  logic [WIDTH-1:0]     rt_data,
  input  logic [IMM_W-1:0]     imm16,
  input  logic                 alu_src,
  input  logic [ALU_OP_W-1:0]  alu_op,
  output logic [CTRL_W-1:0]    ctrl,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic [WIDTH-1:0]     alu_result,
  output logic                 alu_zero,
  output logic [WIDTH-1:0]     ex_result,
  output logic                 ex_zero
);

  ctrl_t            ctrl_w;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] operand_b;

  // Main control; unknown opcodes become a bubble with no side effects
  always_comb begin
    ctrl_w = CTRL_BUBBLE;
    case (opcode)
      OP_RTYPE: ctrl_w = ctrl_t'(8'b1001_0010);
      OP_LW:    ctrl_w = ctrl_t'(8'b0111_0000);
      OP_SW:    ctrl_w = ctrl_t'(8'b0100_1000);
      OP_BEQ:   ctrl_w = ctrl_t'(8'b0000_0101);
      OP_ADDI:  ctrl_w = ctrl_t'(8'b0101_0000);
      default:  ctrl_w = CTRL_BUBBLE;
    endcase
  end

  assign ctrl = CTRL_W'(ctrl_w);

  // ALU control; unrecognised funct falls back to ADD
  always_comb begin
    alu_ctl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctl = ALU_ADD;
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_NOR:  alu_ctl = ALU_NOR;
          FN_SLT:  alu_ctl = ALU_SLT;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

  assign imm_ext   = {{(WIDTH-IMM_W){imm16[IMM_W-1]}}, imm16};
  assign operand_b = alu_src ? imm_ext : rt_data;

  mips_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .ctl    (alu_ctl),
    .a      (rs_data),
    .b      (operand_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // EX output register, no enable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_result <= '0;
      ex_zero   <= 1'b0;
    end else begin
      ex_result <= alu_result;
      ex_zero   <= alu_zero;
    end
  end

endmodule

// File: tb/tb_mips_decode_alu.sv
// Directed, table-driven bench for mips_decode_alu plus EX-register and reset sequences.
module tb_mips_decode_alu;

  logic        clock;
  logic        reset_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm16;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic [7:0]  ctrl;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] ex_result;
  logic        ex_zero;

  int checks = 0;
  int errors = 0;

  mips_decode_alu dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .funct      (funct),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .imm16      (imm16),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .ctrl       (ctrl),
    .alu_ctl    (alu_ctl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .ex_result  (ex_result),
    .ex_zero    (ex_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic        src;
    logic [1:0]  aop;
    logic [7:0]  exp_ctrl;
    logic [3:0]  exp_ctl;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[15];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    opcode  = v.opcode;
    funct   = v.funct;
    rs_data = v.rs;
    rt_data = v.rt;
    imm16   = v.imm;
    alu_src = v.src;
    alu_op  = v.aop;
  endtask

  initial begin
    //         opcode funct rs            rt            imm      src aop    ctrl   ctl    result        zero
    vecs[0]  = '{6'h00, 6'h20, 32'd7,        32'd3,        16'h0000, 1'b0, 2'b10, 8'h92, 4'h2, 32'd10,       1'b0};
    vecs[1]  = '{6'h23, 6'h00, 32'd100,      32'd0,        16'h0008, 1'b1, 2'b00, 8'h70, 4'h2, 32'd108,      1'b0};
    vecs[2]  = '{6'h2B, 6'h00, 32'h20,       32'd0,        16'hFFFC, 1'b1, 2'b00, 8'h48, 4'h2, 32'h1C,       1'b0};
    vecs[3]  = '{6'h04, 6'h2A, 32'd5,        32'd5,        16'h0000, 1'b0, 2'b01, 8'h05, 4'h6, 32'd0,        1'b1};
    vecs[4]  = '{6'h08, 6'h00, 32'hFFFFFFFF, 32'd1,        16'h0000, 1'b0, 2'b00, 8'h50, 4'h2, 32'd0,        1'b1};
    vecs[5]  = '{6'h3F, 6'h22, 32'd10,       32'd3,        16'h0000, 1'b0, 2'b10, 8'h00, 4'h6, 32'd7,        1'b0};
    vecs[6]  = '{6'h00, 6'h24, 32'hF0F0,     32'hFF00,     16'h0000, 1'b0, 2'b10, 8'h92, 4'h0, 32'hF000,     1'b0};
    vecs[7]  = '{6'h00, 6'h25, 32'hF0F0,     32'hFF00,     16'h0000, 1'b0, 2'b10, 8'h92, 4'h1, 32'hFFF0,     1'b0};
    vecs[8]  = '{6'h00, 6'h27, 32'd0,        32'd0,        16'h0000, 1'b0, 2'b10, 8'h92, 4'hC, 32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{6'h00, 6'h2A, 32'hFFFFFFFE, 32'd3,        16'h0000, 1'b0, 2'b10, 8'h92, 4'h7, 32'd1,        1'b0};
    vecs[10] = '{6'h00, 6'h2A, 32'd3,        32'hFFFFFFFE, 16'h0000, 1'b0, 2'b10, 8'h92, 4'h7, 32'd0,        1'b1};
    vecs[11] = '{6'h00, 6'h3F, 32'd1,        32'd2,        16'h0000, 1'b0, 2'b10, 8'h92, 4'h2, 32'd3,        1'b0};
    vecs[12] = '{6'h00, 6'h22, 32'd4,        32'd4,        16'h0000, 1'b0, 2'b11, 8'h92, 4'h2, 32'd8,        1'b0};
    vecs[13] = '{6'h00, 6'h24, 32'd4,        32'd4,        16'h0000, 1'b0, 2'b01, 8'h92, 4'h6, 32'd0,        1'b1};
    vecs[14] = '{6'h08, 6'h00, 32'd16,       32'd99,       16'hFFFC, 1'b1, 2'b00, 8'h50, 4'h2, 32'd12,       1'b0};

    reset_n = 1'b0;
    apply(vecs[0]);
    #2;
    check32("reset_ex_result", ex_result, 32'd0);
    check32("reset_ex_zero", {31'd0, ex_zero}, 32'd0);
    check32("reset_comb_result", alu_result, 32'd10);

    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clock);
      apply(vecs[i]);
      #1;
      check32($sformatf("v%0d_ctrl", i), {24'd0, ctrl}, {24'd0, vecs[i].exp_ctrl});
      check32($sformatf("v%0d_alu_ctl", i), {28'd0, alu_ctl}, {28'd0, vecs[i].exp_ctl});
      check32($sformatf("v%0d_result", i), alu_result, vecs[i].exp_res);
      check32($sformatf("v%0d_zero", i), {31'd0, alu_zero}, {31'd0, vecs[i].exp_zero});
    end

    // Immediate add captured into EX register one edge later
    @(posedge clock);
    #1;
    check32("ex_result_imm", ex_result, 32'd12);
    check32("ex_zero_imm", {31'd0, ex_zero}, 32'd0);

    // Zero result captured with ex_zero set
    apply(vecs[3]);
    @(posedge clock);
    #1;
    check32("ex_result_sub", ex_result, 32'd0);
    check32("ex_zero_sub", {31'd0, ex_zero}, 32'd1);

    apply(vecs[14]);
    @(posedge clock);
    #1;
    check32("ex_result_reload", ex_result, 32'd12);

    // Async reset mid-cycle clears immediately, holds, then releases on an edge
    #2;
    reset_n = 1'b0;
    #1;
    check32("async_clear_result", ex_result, 32'd0);
    check32("async_clear_zero", {31'd0, ex_zero}, 32'd0);
    check32("comb_in_reset", alu_result, 32'd12);
    repeat (2) @(posedge clock);
    #1;
    check32("hold_reset_result", ex_result, 32'd0);
    check32("hold_reset_zero", {31'd0, ex_zero}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check32("release_no_edge", ex_result, 32'd0);
    @(posedge clock);
    #1;
    check32("release_capture", ex_result, 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
